// File: rtl/mem_arbiter_pkg.sv
// Shared constants for the memory-port arbiter: read tag encoding and burst default.
package mem_arbiter_pkg;

  localparam int unsigned BURST_BITS_DEF = 2;
  localparam int unsigned NPORTS_DEF     = 3;

  localparam logic [1:0] ID_NONE  = 2'd0;
  localparam logic [1:0] ID_PORT0 = 2'd1;
  localparam logic [1:0] ID_PORT1 = 2'd2;
  localparam logic [1:0] ID_PORT2 = 2'd3;

  function automatic logic [1:0] port_id(input logic [1:0] port);
    case (port)
      2'd0:    return ID_PORT0;
      2'd1:    return ID_PORT1;
      default: return ID_PORT2;
    endcase
  endfunction

  function automatic logic [1:0] next_port(input logic [1:0] port);
    return (port == 2'd2) ? 2'd0 : port + 2'd1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick3.sv
// Combinational 3-way round-robin selector: first eligible port scanning rr, rr+1, rr+2.
module rr_pick3 (
  input  logic [2:0] eligible,
  input  logic [1:0] rr,
  output logic [2:0] grant,
  output logic       valid
);

  logic [1:0] port;
  logic       found;

  always_comb begin
    grant = '0;
    found = 1'b0;
    port  = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      port = 2'((32'(rr) + k) % 3);
      if (!found && eligible[port]) begin
        grant[port] = 1'b1;
        found       = 1'b1;
      end
    end
    valid = |eligible;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-port arbiter for the burst-read memory controller port, with stall lock
// and per-port read-burst tracking; read beats return by tag.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned BURST_BITS      = BURST_BITS_DEF,
  parameter bit          ONE_OUTSTANDING = 1'b1,
  parameter int unsigned NPORTS          = NPORTS_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        m0_read,
  input  logic        m0_write,
  input  logic [29:0] m0_address,
  input  logic [31:0] m0_writedata,
  input  logic [3:0]  m0_writedatamask,
  output logic        m0_waitrequest,
  output logic [31:0] m0_readdata,
  output logic        m0_readdatavalid,
  input  logic        m1_read,
  input  logic        m1_write,
  input  logic [29:0] m1_address,
  input  logic [31:0] m1_writedata,
  input  logic [3:0]  m1_writedatamask,
  output logic        m1_waitrequest,
  output logic [31:0] m1_readdata,
  output logic        m1_readdatavalid,
  input  logic        m2_read,
  input  logic        m2_write,
  input  logic [29:0] m2_address,
  input  logic [31:0] m2_writedata,
  input  logic [3:0]  m2_writedatamask,
  output logic        m2_waitrequest,
  output logic [31:0] m2_readdata,
  output logic        m2_readdatavalid,
  input  logic        mem_waitrequest,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  input  logic [31:0] mem_readdata,
  input  logic [1:0]  mem_readdataid
);

  logic [NPORTS-1:0] rd, wr, eligible, pend, wait_v, valid_v;
  logic [29:0]       addr  [NPORTS];
  logic [31:0]       wdata [NPORTS];
  logic [3:0]        wmask [NPORTS];

  logic [BURST_BITS-1:0] beat [NPORTS];
  logic [1:0]            rr, lock_port, gidx, pick_idx;
  logic                  locked, gvalid, pick_valid, present, accept;
  logic [NPORTS-1:0]     pick_grant;

  assign rd = {m2_read, m1_read, m0_read};
  assign wr = {m2_write, m1_write, m0_write};
  assign addr[0] = m0_address;       assign addr[1] = m1_address;       assign addr[2] = m2_address;
  assign wdata[0] = m0_writedata;    assign wdata[1] = m1_writedata;    assign wdata[2] = m2_writedata;
  assign wmask[0] = m0_writedatamask; assign wmask[1] = m1_writedatamask; assign wmask[2] = m2_writedatamask;

  // Writes stay eligible while a read burst is outstanding; only a repeat read is held off.
  always_comb begin
    for (int unsigned n = 0; n < NPORTS; n++)
      eligible[n] = (rd[n] | wr[n]) && !(ONE_OUTSTANDING && pend[n] && rd[n]);
  end

  rr_pick3 u_pick (
    .eligible (eligible),
    .rr       (rr),
    .grant    (pick_grant),
    .valid    (pick_valid)
  );

  assign pick_idx = pick_grant[1] ? 2'd1 : (pick_grant[2] ? 2'd2 : 2'd0);
  assign gvalid   = locked | pick_valid;
  assign gidx     = locked ? lock_port : pick_idx;

  always_comb begin
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    mem_id            = ID_NONE;
    mem_address       = '0;
    mem_writedata     = '0;
    mem_writedatamask = '0;
    if (gvalid) begin
      mem_read          = rd[gidx];
      mem_write         = wr[gidx] & ~rd[gidx];
      mem_id            = rd[gidx] ? port_id(gidx) : ID_NONE;
      mem_address       = addr[gidx];
      mem_writedata     = wdata[gidx];
      mem_writedatamask = wmask[gidx];
    end
  end

  always_comb begin
    for (int unsigned n = 0; n < NPORTS; n++) begin
      wait_v[n]  = !gvalid || (gidx != 2'(n)) || mem_waitrequest || !eligible[n];
      valid_v[n] = (mem_readdataid == port_id(2'(n)));
    end
  end

  assign {m2_waitrequest, m1_waitrequest, m0_waitrequest}       = wait_v;
  assign {m2_readdatavalid, m1_readdatavalid, m0_readdatavalid} = valid_v;
  assign m0_readdata = mem_readdata;
  assign m1_readdata = mem_readdata;
  assign m2_readdata = mem_readdata;

  assign present = mem_read | mem_write;
  assign accept  = present & ~mem_waitrequest;

  always_ff @(posedge clock) begin
    if (reset) begin
      rr        <= '0;
      locked    <= 1'b0;
      lock_port <= '0;
      pend      <= '0;
      for (int unsigned n = 0; n < NPORTS; n++) beat[n] <= '0;
    end else begin
      if (accept) begin
        rr     <= next_port(gidx);
        locked <= 1'b0;
      end else if (present && mem_waitrequest) begin
        locked    <= 1'b1;
        lock_port <= gidx;
      end
      // A new accepted read outranks the last beat of the previous burst on the same port.
      for (int unsigned n = 0; n < NPORTS; n++) begin
        if (accept && mem_read && gidx == 2'(n)) begin
          pend[n] <= 1'b1;
          beat[n] <= '0;
        end else if (pend[n] && mem_readdataid == port_id(2'(n))) begin
          beat[n] <= beat[n] + 1'b1;
          if (&beat[n]) pend[n] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed masters push expected commands/beats,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_arbiter;

  logic        clock = 1'b0;
  logic        reset;
  logic        rd [3];
  logic        wr [3];
  logic [29:0] addr [3];
  logic [31:0] wdata [3];
  logic [3:0]  wmask [3];
  logic [2:0]  wq, rvalid;
  logic [31:0] rdo [3];
  logic        mwait;
  logic [1:0]  mem_id, rid;
  logic [29:0] mem_address;
  logic        mem_read, mem_write;
  logic [31:0] mem_writedata, rdata;
  logic [3:0]  mem_writedatamask;

  int checks = 0;
  int failures = 0;
  logic [69:0] cmd_q [$];
  logic [98:0] beat_q [$];

  always #5 clock = ~clock;

  mem_arbiter #(.BURST_BITS(2), .ONE_OUTSTANDING(1'b1), .NPORTS(3)) dut (
    .clock(clock), .reset(reset),
    .m0_read(rd[0]), .m0_write(wr[0]), .m0_address(addr[0]), .m0_writedata(wdata[0]),
    .m0_writedatamask(wmask[0]), .m0_waitrequest(wq[0]), .m0_readdata(rdo[0]), .m0_readdatavalid(rvalid[0]),
    .m1_read(rd[1]), .m1_write(wr[1]), .m1_address(addr[1]), .m1_writedata(wdata[1]),
    .m1_writedatamask(wmask[1]), .m1_waitrequest(wq[1]), .m1_readdata(rdo[1]), .m1_readdatavalid(rvalid[1]),
    .m2_read(rd[2]), .m2_write(wr[2]), .m2_address(addr[2]), .m2_writedata(wdata[2]),
    .m2_writedatamask(wmask[2]), .m2_waitrequest(wq[2]), .m2_readdata(rdo[2]), .m2_readdatavalid(rvalid[2]),
    .mem_waitrequest(mwait), .mem_id(mem_id), .mem_address(mem_address), .mem_read(mem_read),
    .mem_write(mem_write), .mem_writedata(mem_writedata), .mem_writedatamask(mem_writedatamask),
    .mem_readdata(rdata), .mem_readdataid(rid)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [69:0] cmd(input logic r, input logic w, input logic [1:0] id,
                                      input logic [29:0] a, input logic [31:0] d, input logic [3:0] m);
    return {r, w, id, a, d, m};
  endfunction

  // Drive one master command from posedge+1, hold until accepted, release at next posedge+1.
  task automatic master(input int p, input logic r, input logic w, input logic [29:0] a,
                        input logic [31:0] d, input logic [3:0] m, input int exp_wait, input string name);
    int waited = 0;
    rd[p] = r; wr[p] = w; addr[p] = a; wdata[p] = d; wmask[p] = m;
    while (1) begin
      @(negedge clock);
      if (!wq[p]) break;
      waited++;
      if (waited > 40) break;
    end
    if (waited > 40) check({name, "_timeout"}, 128'(waited), 128'(exp_wait));
    else check({name, "_wait"}, 128'(waited), 128'(exp_wait));
    @(posedge clock); #1;
    rd[p] = 1'b0; wr[p] = 1'b0; addr[p] = '0; wdata[p] = '0; wmask[p] = '0;
  endtask

  task automatic beat(input logic [1:0] id, input logic [31:0] d, input logic [2:0] exp_v);
    rid = id; rdata = d;
    if (id != 2'd0) beat_q.push_back({exp_v, d, d, d});
    @(posedge clock); #1;
    rid = '0; rdata = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;
  endtask

  initial begin : monitor
    logic [69:0] ec;
    logic [98:0] eb;
    forever begin
      @(negedge clock);
      if (!reset) begin
        if ((mem_read | mem_write) && !mwait) begin
          if (cmd_q.size() == 0) check("cmd_unexpected", 128'(1), 128'(0));
          else begin
            ec = cmd_q.pop_front();
            check("cmd", 128'({mem_read, mem_write, mem_id, mem_address, mem_writedata, mem_writedatamask}), 128'(ec));
          end
        end
        if (rid != 2'd0) begin
          if (beat_q.size() == 0) check("beat_unexpected", 128'(1), 128'(0));
          else begin
            eb = beat_q.pop_front();
            check("beat", 128'({rvalid, rdo[0], rdo[1], rdo[2]}), 128'(eb));
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    for (int i = 0; i < 3; i++) begin
      rd[i] = 1'b0; wr[i] = 1'b0; addr[i] = '0; wdata[i] = '0; wmask[i] = '0;
    end
    reset = 1'b1; mwait = 1'b0; rid = '0; rdata = '0;

    @(negedge clock);
    check("reset_cmd", 128'({mem_read, mem_write, mem_id, mem_address, mem_writedata, mem_writedatamask}), 128'(0));
    check("reset_wait", 128'(wq), 128'(3'b111));
    check("reset_valid", 128'(rvalid), 128'(0));
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // Contention from rr=0: ports accepted 0,1,2.
    cmd_q.push_back(cmd(1, 0, 2'd1, 30'h10, 0, 0));
    cmd_q.push_back(cmd(1, 0, 2'd2, 30'h20, 0, 0));
    cmd_q.push_back(cmd(1, 0, 2'd3, 30'h30, 0, 0));
    fork
      master(0, 1, 0, 30'h10, 0, 0, 0, "cont_p0");
      master(1, 1, 0, 30'h20, 0, 0, 1, "cont_p1");
      master(2, 1, 0, 30'h30, 0, 0, 2, "cont_p2");
    join
    for (int i = 0; i < 2; i++) beat(2'd2, 32'h2000_0000 + 32'(i), 3'b010);
    for (int i = 0; i < 4; i++) beat(2'd1, 32'h1000_0000 + 32'(i), 3'b001);
    for (int i = 2; i < 4; i++) beat(2'd2, 32'h2000_0000 + 32'(i), 3'b010);
    for (int i = 0; i < 4; i++) beat(2'd3, 32'h3000_0000 + 32'(i), 3'b100);

    // Single read, then a write while the burst is outstanding, then a held-off repeat read.
    cmd_q.push_back(cmd(1, 0, 2'd1, 30'h100, 0, 0));
    master(0, 1, 0, 30'h100, 0, 0, 0, "single_read");
    cmd_q.push_back(cmd(0, 1, 2'd0, 30'h200, 32'hCAFE_F00D, 4'b1010));
    master(0, 0, 1, 30'h200, 32'hCAFE_F00D, 4'b1010, 0, "write_while_pend");
    cmd_q.push_back(cmd(1, 0, 2'd1, 30'h104, 0, 0));
    fork
      master(0, 1, 0, 30'h104, 0, 0, 4, "one_outstanding");
      for (int i = 0; i < 4; i++) beat(2'd1, 32'hA0 + 32'(i), 3'b001);
    join
    for (int i = 0; i < 4; i++) beat(2'd1, 32'hB0 + 32'(i), 3'b001);

    // Stall lock: m1 write held for 3 stalled cycles while m0 raises a read.
    mwait = 1'b1;
    cmd_q.push_back(cmd(0, 1, 2'd0, 30'h2AA, 32'h1234_5678, 4'b0011));
    cmd_q.push_back(cmd(1, 0, 2'd1, 30'h0C0, 0, 0));
    fork
      master(1, 0, 1, 30'h2AA, 32'h1234_5678, 4'b0011, 3, "lock_m1");
      begin @(posedge clock); #1; master(0, 1, 0, 30'h0C0, 0, 0, 3, "lock_m0"); end
      begin
        repeat (3) begin
          @(negedge clock);
          check("lock_addr", 128'(mem_address), 128'(30'h2AA));
          check("lock_m0_wait", 128'(wq[0]), 128'(1));
        end
        @(posedge clock); #1 mwait = 1'b0;
      end
    join
    for (int i = 0; i < 4; i++) beat(2'd1, 32'hC0 + 32'(i), 3'b001);

    // Mixed traffic: port 2 write then read, with id-1 beats interleaved.
    cmd_q.push_back(cmd(1, 0, 2'd1, 30'h400, 0, 0));
    master(0, 1, 0, 30'h400, 0, 0, 0, "mixed_m0");
    cmd_q.push_back(cmd(0, 1, 2'd0, 30'h300, 32'h1111_2222, 4'hF));
    cmd_q.push_back(cmd(1, 0, 2'd3, 30'h304, 0, 0));
    fork
      begin
        master(2, 0, 1, 30'h300, 32'h1111_2222, 4'hF, 0, "mixed_w2");
        master(2, 1, 0, 30'h304, 0, 0, 0, "mixed_r2");
      end
      for (int i = 0; i < 4; i++) beat(2'd1, 32'hD0 + 32'(i), 3'b001);
    join
    for (int i = 0; i < 4; i++) beat(2'd3, 32'hE0 + 32'(i), 3'b100);
    beat(2'd2, 32'h5A5A, 3'b010);
    rid = 2'd0; rdata = 32'hFFFF_0000;
    @(negedge clock);
    check("id0_valid", 128'(rvalid), 128'(0));
    check("broadcast", 128'({rdo[0], rdo[1], rdo[2]}), 128'({3{32'hFFFF_0000}}));
    @(posedge clock); #1 rdata = '0;

    // Reset mid-burst: 2 of 4 id-2 beats, then reset clears pend1 and rr.
    cmd_q.push_back(cmd(1, 0, 2'd2, 30'h500, 0, 0));
    master(1, 1, 0, 30'h500, 0, 0, 0, "burst_m1");
    for (int i = 0; i < 2; i++) beat(2'd2, 32'hF0 + 32'(i), 3'b010);
    do_reset();
    cmd_q.push_back(cmd(1, 0, 2'd2, 30'h600, 0, 0));
    cmd_q.push_back(cmd(1, 0, 2'd3, 30'h700, 0, 0));
    fork
      master(1, 1, 0, 30'h600, 0, 0, 0, "post_reset_m1");
      master(2, 1, 0, 30'h700, 0, 0, 1, "post_reset_m2");
    join

    @(negedge clock);
    check("cmd_q_drained", 128'(cmd_q.size()), 128'(0));
    check("beat_q_drained", 128'(beat_q.size()), 128'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single word-addressed, burst-read SSRAM/flash memory controller port between three requesters: port 0 instruction-cache fill, port 1 data-cache fill/store, port 2 DMA/debug.
- Forwards one command at a time and tags each read with a fixed id (port index + 1).
- Routes returning read beats back to the owning port by id.
- Arbitration is round-robin, with a grant lock that holds a presented command stable while the controller stalls.

Parameters:
- BURST_BITS, 2, log2 of read burst length; each read returns 1<<BURST_BITS tagged beats.
- ONE_OUTSTANDING, 1, if 1 a port with an unfinished read burst is not granted again until its last beat returns.
- NPORTS, 3, fixed; documents the port count (ids 1..3, id 0 = no data).

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- mN_read  in  1  read request, N=0..2
- mN_write  in  1  write request, N=0..2
- mN_address  in  30  word address, N=0..2
- mN_writedata  in  32  write data, N=0..2
- mN_writedatamask  in  4  byte enables, N=0..2
- mN_waitrequest  out  1  command not accepted this cycle, N=0..2
- mN_readdata  out  32  read beat data, N=0..2
- mN_readdatavalid  out  1  beat valid for port N, N=0..2
- mem_waitrequest  in  1  controller stall
- mem_id  out  2  tag of forwarded command
- mem_address  out  30  forwarded address
- mem_read  out  1  forwarded read
- mem_write  out  1  forwarded write
- mem_writedata  out  32  forwarded data
- mem_writedatamask  out  4  forwarded mask
- mem_readdata  in  32  returned beat
- mem_readdataid  in  2  returned tag, 0 = none

Behaviour:
- **Request and eligibility.** Port N requests when mN_read or mN_write is high. It is eligible unless ONE_OUTSTANDING and pendN is set and it requests a read; writes are always eligible.
- **Grant selection.**
  - When unlocked, grant goes to the first eligible port scanning rr, rr+1, rr+2 (mod 3).
  - When locked, grant = lock_port regardless of other requests.
  - When nothing is eligible, there is no grant.
- **Forwarding (combinational, zero latency).**
  - mem_read/write/address/writedata/writedatamask = the granted port's inputs.
  - mem_id = grant+1 for reads and 0 for writes.
  - With no grant: mem_read = mem_write = 0, all other mem_* outputs = 0.
- **Waitrequest.** mN_waitrequest = (grant != N) || mem_waitrequest || !eligibleN.
- **Accept and lock registers.**
  - accept = (mem_read|mem_write) && !mem_waitrequest.
  - On accept: rr <= grant+1 (mod 3), locked <= 0.
  - When a command is presented and mem_waitrequest is high: locked <= 1, lock_port <= grant.
  - A locked port must keep its request stable; deasserting it is a master protocol error and is not checked.
- **Pending tracking.**
  - On accepted read from port N: pendN <= 1, beatN <= 0.
  - For each cycle with mem_readdataid == N+1: beatN <= beatN+1; when beatN reaches all ones, pendN <= 0.
  - An accept and the last beat of the same port in one cycle: pend stays 1 (the new read wins) and beat resets to 0.
- **Return path (combinational).**
  - mN_readdatavalid = (mem_readdataid == N+1).
  - mN_readdata = mem_readdata, broadcast to all ports; only the valid flag is per-port.
  - Beats with id 0 or an id with no pending read are ignored; pend/beat are unaffected and valid is still driven from id.
- **Reset** (synchronous, overrides all updates):
  - rr=0, locked=0, lock_port=0, all pendN=0, beatN=0.
  - Outputs follow combinationally from inputs (with no inputs asserted: mem_* = 0, all mN_waitrequest = 1, all readdatavalid = 0 given id 0).
  - A reset mid-burst discards the remaining beats; the controller is reset by the same signal.
- **Simultaneous events.**
  - All three ports request in one cycle: exactly one is forwarded.
  - Write and read on the same port in one cycle: read has priority and the write stays waiting.

Decomposition:
- Shared package: ID_NONE=0, port-to-id mapping constants, BURST_BITS default.
- One natural sub-module, rr_pick3: combinational 3-way round-robin selector (inputs: eligible vector and rr; output: one-hot grant plus a valid flag).

Test Plan:
- **Single read.** m0_read @0x100, mem_waitrequest=0 → mem_id=1 same cycle; rr becomes 1; four beats with id 1 assert m0_readdatavalid only; pend0 clears after the 4th.
- **Contention.** All three read at once → accepted order 0,1,2 over three accept cycles (rr=0 start); mem_id sequence 1,2,3.
- **Stall lock.** m1_write with mem_waitrequest=1 for 3 cycles while m0 raises a read → mem_address stays m1's for all 3 cycles; m0 is granted only after the m1 accept.
- **One outstanding.** m0 reads, then reads again before its beats return (ONE_OUTSTANDING=1) → m0_waitrequest stays 1 until the cycle after the 4th id-1 beat; an m0 write in that window is still accepted.
- **Mixed traffic.** A write followed by a read from port 2 → write forwarded with mem_id=0, read with mem_id=3; interleaved id-1 beats route only to port 0.
- **Reset mid-burst.** Reset after 2 of 4 id-2 beats → pend1=0, rr=0, locked=0; the next m1 read is granted immediately.
